// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared widths and buffer entry type for the instruction prefetcher.
package prefetch_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_BYTES = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0] instr;
  } entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: in-order synchronous buffer of {pc, instr} entries with flush.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a pop frees the slot, so a full buffer can still take a push that cycle
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge i_Clk)
    if (do_push & ~flush) mem[wr_ptr] <= din;
  always_ff @(posedge i_Clk) begin
    if (i_Reset | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: Avalon read-master instruction prefetcher feeding an in-order buffer.
// Define INSTR_PREFETCH_ALIGN_CHECK_EN to add misaligned-redirect halting and o_AlignErr.
module instr_prefetch
  import prefetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  output logic [ADDR_W-1:0] o_AV_Addr,
  output logic              o_AV_Read,
  input  logic [31:0]       i_AV_ReadData,
  input  logic              i_AV_WaitRequest,
  output logic [31:0]       o_Instr,
  output logic [ADDR_W-1:0] o_Pc,
  output logic              o_Valid,
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
  output logic              o_AlignErr,
`endif
  input  logic              i_Ready,
  input  logic              i_Redirect,
  input  logic [ADDR_W-1:0] i_RedirectPc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] pc_q;
  logic inflight_q, halt, accept, full_unused, empty;
  logic [CW-1:0] count;
  entry_t head;
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge i_Clk)
    if (i_Reset) err_q <= 1'b0;
    else if (i_Redirect) err_q <= |i_RedirectPc[1:0];
  assign halt = err_q;
  assign o_AlignErr = err_q & ~i_Reset;
`else
  logic unused_align;
  assign unused_align = ^i_RedirectPc[1:0];
  assign halt = 1'b0;
`endif
  // reserve a slot for the in-flight read so its data always has room on return
  assign o_AV_Read = ~i_Reset & ~i_Redirect & ~halt & ((count + CW'(inflight_q)) < CW'(DEPTH));
  assign o_AV_Addr = pc_q;
  assign accept = o_AV_Read & ~i_AV_WaitRequest;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pc_q       <= {RESET_PC[ADDR_W-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else if (i_Redirect) begin
      pc_q       <= {i_RedirectPc[ADDR_W-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) pc_q <= pc_q + ADDR_W'(WORD_BYTES);
    end
  end
  // pc_q has already advanced past the returning read, so its address is pc_q - 4
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .push    (inflight_q & ~i_Redirect),
    .pop     (o_Valid & i_Ready),
    .flush   (i_Redirect),
    .din     ('{pc: pc_q - ADDR_W'(WORD_BYTES), instr: i_AV_ReadData}),
    .dout    (head),
    .count   (count),
    .full    (full_unused),
    .empty   (empty)
  );
  assign o_Valid = ~empty & ~i_Reset;
  assign o_Instr = o_Valid ? head.instr : '0;
  assign o_Pc = o_Valid ? head.pc : '0;
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed scoreboard bench; slave returns addr ^ 32'hA5A5_0000 one cycle after accept.
module tb_instr_prefetch;
  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  logic [31:0] o_AV_Addr;
  logic o_AV_Read;
  logic [31:0] i_AV_ReadData = '0;
  logic i_AV_WaitRequest = 1'b0;
  logic [31:0] o_Instr, o_Pc;
  logic o_Valid;
  logic i_Ready = 1'b0;
  logic i_Redirect = 1'b0;
  logic [31:0] i_RedirectPc = '0;
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
  logic o_AlignErr;
`endif
  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q [$];
  logic sl_acc;
  logic [31:0] sl_addr;
  always #5 i_Clk = ~i_Clk;
  instr_prefetch #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .i_Clk            (i_Clk),
    .i_Reset          (i_Reset),
    .o_AV_Addr        (o_AV_Addr),
    .o_AV_Read        (o_AV_Read),
    .i_AV_ReadData    (i_AV_ReadData),
    .i_AV_WaitRequest (i_AV_WaitRequest),
    .o_Instr          (o_Instr),
    .o_Pc             (o_Pc),
    .o_Valid          (o_Valid),
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
    .o_AlignErr       (o_AlignErr),
`endif
    .i_Ready          (i_Ready),
    .i_Redirect       (i_Redirect),
    .i_RedirectPc     (i_RedirectPc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask
  // fixed-latency slave: a read accepted in cycle t returns data in cycle t+1
  initial forever begin
    @(negedge i_Clk);
    sl_acc = o_AV_Read & ~i_AV_WaitRequest;
    sl_addr = o_AV_Addr;
    @(posedge i_Clk);
    #1;
    if (sl_acc) i_AV_ReadData = sl_addr ^ 32'hA5A5_0000;
  end
  // monitor: every accepted head (outside a redirect cycle) must match the scoreboard
  initial forever begin
    @(negedge i_Clk);
    if (o_Valid && i_Ready && !i_Redirect) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pc %h, expected no output", o_Pc);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("out_pc", o_Pc, e);
        chk("out_instr", o_Instr, e ^ 32'hA5A5_0000);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end
  task automatic do_reset();
    i_Reset = 1'b1;
    i_Ready = 1'b0;
    i_Redirect = 1'b0;
    i_AV_WaitRequest = 1'b0;
    sb_q.delete();
    tick();
    #1;
    chk("rst_read", 32'(o_AV_Read), 0);
    chk("rst_valid", 32'(o_Valid), 0);
    chk("rst_instr", o_Instr, 0);
    chk("rst_pc", o_Pc, 0);
    tick();
    i_Reset = 1'b0;
    #1;
  endtask
  initial begin
    int nv, nr;
    // throughput after reset release
    do_reset();
    i_Ready = 1'b1;
    for (int k = 0; k < 8; k++) sb_q.push_back(32'(4 * k));
    chk("t1_read0", 32'(o_AV_Read), 1);
    chk("t1_addr0", o_AV_Addr, 32'h0);
    tick(); #1;
    chk("t1_addr1", o_AV_Addr, 32'h4);
    chk("t1_valid1", 32'(o_Valid), 0);
    nv = 0;
    for (int c = 2; c <= 9; c++) begin
      tick(); #1;
      if (c == 2) chk("t1_valid2", 32'(o_Valid), 1);
      nv += int'(o_Valid);
    end
    chk("t1_throughput", 32'(nv), 8);
    tick(); i_Ready = 1'b0; #1;
    chk("t1_drained", 32'(sb_q.size()), 0);
    // backpressure fills DEPTH then one pop frees one read
    do_reset();
    nr = int'(o_AV_Read & ~i_AV_WaitRequest);
    for (int c = 1; c <= 9; c++) begin
      tick(); #1;
      nr += int'(o_AV_Read & ~i_AV_WaitRequest);
    end
    chk("t2_reads", 32'(nr), 4);
    chk("t2_read_off", 32'(o_AV_Read), 0);
    sb_q.push_back(32'h0);
    tick(); i_Ready = 1'b1; #1;
    chk("t2_full_noread", 32'(o_AV_Read), 0);
    tick(); i_Ready = 1'b0; #1;
    chk("t2_refill_read", 32'(o_AV_Read), 1);
    chk("t2_refill_addr", o_AV_Addr, 32'h10);
    tick(); #1;
    chk("t2_one_only_a", 32'(o_AV_Read), 0);
    tick(); #1;
    chk("t2_one_only_b", 32'(o_AV_Read), 0);
    chk("t2_head", o_Pc, 32'h4);
    chk("t2_drained", 32'(sb_q.size()), 0);
    // wait-request stall on the read at 0x10
    do_reset();
    i_Ready = 1'b1;
    for (int k = 0; k < 7; k++) sb_q.push_back(32'(4 * k));
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) tick();
      i_AV_WaitRequest = (c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 7) begin
        chk("t3_stall_addr", o_AV_Addr, 32'h10);
        chk("t3_stall_read", 32'(o_AV_Read), 1);
      end
      if (c >= 6 && c <= 8) chk("t3_gap", 32'(o_Valid), 0);
    end
    tick(); i_Ready = 1'b0; #1;
    chk("t3_drained", 32'(sb_q.size()), 0);
    // redirect in the cycle the 0x0C response returns
    do_reset();
    i_Ready = 1'b1;
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    for (int c = 1; c <= 3; c++) tick();
    tick(); i_Redirect = 1'b1; i_RedirectPc = 32'h100; #1;
    chk("t4_redir_read", 32'(o_AV_Read), 0);
    chk("t4_pre_drained", 32'(sb_q.size()), 0);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h104);
    tick(); i_Redirect = 1'b0; #1;
    chk("t4_read", 32'(o_AV_Read), 1);
    chk("t4_addr", o_AV_Addr, 32'h100);
    chk("t4_flushed", 32'(o_Valid), 0);
    tick(); #1;
    chk("t4_nostale", 32'(o_Valid), 0);
    tick(); #1;
    chk("t4_valid", 32'(o_Valid), 1);
    tick();
    tick(); i_Ready = 1'b0; #1;
    chk("t4_drained", 32'(sb_q.size()), 0);
    // back-to-back redirects: last wins
    tick(); i_Redirect = 1'b1; i_RedirectPc = 32'h300; #1;
    chk("t7_read_a", 32'(o_AV_Read), 0);
    tick(); i_RedirectPc = 32'h400; #1;
    chk("t7_read_b", 32'(o_AV_Read), 0);
    tick(); i_Redirect = 1'b0; #1;
    chk("t7_addr", o_AV_Addr, 32'h400);
    chk("t7_valid", 32'(o_Valid), 0);
    // reset with 3 buffered entries and a response returning
    do_reset();
    for (int c = 1; c <= 3; c++) tick();
    tick(); i_Reset = 1'b1; #1;
    chk("t5_valid_rst", 32'(o_Valid), 0);
    chk("t5_read_rst", 32'(o_AV_Read), 0);
    chk("t5_pc_rst", o_Pc, 0);
    tick(); i_Reset = 1'b0; #1;
    chk("t5_restart_read", 32'(o_AV_Read), 1);
    chk("t5_restart_addr", o_AV_Addr, 32'h0);
    chk("t5_empty_a", 32'(o_Valid), 0);
    tick(); #1;
    chk("t5_empty_b", 32'(o_Valid), 0);
    tick(); sb_q.push_back(32'h0); i_Ready = 1'b1; #1;
    chk("t5_valid", 32'(o_Valid), 1);
    tick(); i_Ready = 1'b0; #1;
    chk("t5_drained", 32'(sb_q.size()), 0);
    // misaligned redirect
    do_reset();
    tick(); i_Redirect = 1'b1; i_RedirectPc = 32'h102; #1;
    chk("t6_redir_read", 32'(o_AV_Read), 0);
    tick(); i_Redirect = 1'b0; #1;
    chk("t6_valid", 32'(o_Valid), 0);
`ifdef INSTR_PREFETCH_ALIGN_CHECK_EN
    chk("t6_err_set", 32'(o_AlignErr), 1);
    chk("t6_halt_a", 32'(o_AV_Read), 0);
    tick(); #1;
    chk("t6_halt_b", 32'(o_AV_Read), 0);
    tick(); i_Redirect = 1'b1; i_RedirectPc = 32'h200; #1;
    chk("t6_err_held", 32'(o_AlignErr), 1);
    tick(); i_Redirect = 1'b0; #1;
    chk("t6_err_clr", 32'(o_AlignErr), 0);
    chk("t6_read", 32'(o_AV_Read), 1);
    chk("t6_addr", o_AV_Addr, 32'h200);
`else
    chk("t6_trunc_read", 32'(o_AV_Read), 1);
    chk("t6_trunc_addr", o_AV_Addr, 32'h100);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries; a power of two, at least 2.
REQ-003 i_Clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 o_AV_Addr  out  32  Avalon read-master byte address; bits [1:0] always 0.
REQ-006 o_AV_Read  out  1  Avalon read request.
REQ-007 i_AV_ReadData  in  32  Avalon read data.
REQ-008 i_AV_WaitRequest  in  1  slave stall; the read is held while this is high.
REQ-009 o_Instr  out  32  instruction word at the buffer head.
REQ-010 o_Pc  out  32  byte address of o_Instr.
REQ-011 o_Valid  out  1  buffer head holds a valid instruction.
REQ-012 i_Ready  in  1  consumer accepts the head; a pop occurs when o_Valid and i_Ready are both high.
REQ-013 i_Redirect  in  1  flush and restart fetch.
REQ-014 i_RedirectPc  in  32  new fetch byte address.
REQ-015 o_AlignErr  out  1  sticky misaligned-redirect flag; present only under REQ-036.

Function
REQ-016 A read is accepted in a cycle where o_AV_Read=1 and i_AV_WaitRequest=0.
REQ-017 The slave latency is fixed at 1: data for a read accepted in cycle t is on i_AV_ReadData in cycle t+1 and is written to the buffer at the end of t+1.
REQ-018 A written entry makes o_Valid high in cycle t+2; there is no bypass path.
REQ-019 o_AV_Read is high only when the buffer occupancy plus in-flight reads (0 or 1) is less than DEPTH, no redirect is active, and fetch is not halted.
REQ-020 While i_AV_WaitRequest=1, o_AV_Addr and o_AV_Read hold stable.
REQ-021 After each accepted read, the fetch PC advances by 4 and wraps modulo 2^32.
REQ-022 The buffer is in-order; each entry stores {pc, instr}. A push and a pop in the same cycle leave the occupancy unchanged, including when the buffer is full.
REQ-023 When the buffer is empty, o_Valid=0, and o_Instr and o_Pc are 0.
REQ-024 In a cycle with i_Redirect=1: o_AV_Read=0, the buffer is emptied, any concurrent pop is ignored, and the fetch PC is loaded from {i_RedirectPc[31:2],2'b00}.
REQ-025 A read in flight at a redirect is discarded when its data returns; it is not written to the buffer.
REQ-026 A response returning in the same cycle as i_Redirect is discarded.
REQ-027 The first read after a redirect is issued in the cycle after the redirect.
REQ-028 Back-to-back redirects: the last one wins.
REQ-029 With WaitRequest=0 and the consumer always ready, sustained throughput is one instruction per cycle.

Reset
REQ-030 While i_Reset=1: o_AV_Read=0, o_Valid=0, o_Instr=0, o_Pc=0, o_AlignErr=0, the buffer is empty, the fetch PC equals RESET_PC, and any in-flight read is marked discarded.
REQ-031 A reset asserted mid-read drops that read's response, regardless of WaitRequest.
REQ-032 The first read is issued in the first cycle after i_Reset falls, at o_AV_Addr=RESET_PC.

Configuration
REQ-033 Macro INSTR_PREFETCH_ALIGN_CHECK_EN enables misaligned-redirect checking.
REQ-034 When defined: a redirect with i_RedirectPc[1:0]!=0 sets o_AlignErr, empties the buffer, and halts fetch.
REQ-035 When defined: the halt and o_AlignErr clear only on an aligned redirect or on reset.
REQ-036 When defined: the o_AlignErr port exists.
REQ-037 When undefined: the o_AlignErr port is absent, and i_RedirectPc[1:0] is ignored (truncated).

Structure
REQ-038 Shared package prefetch_pkg holds: the word-size constant (4 bytes), the address width (32), and the buffer entry type {pc[31:0], instr[31:0]}.
REQ-039 The buffer is sub-module prefetch_fifo, a synchronous FIFO with push, pop, flush, count, full and empty; the read-master control logic stays in instr_prefetch.

Verification
REQ-040 Reset release, RESET_PC=0, slave returns addr^32'hA5A5_0000, i_Ready=1 -> reads at 0,4,8,...; first o_Valid 2 cycles after the first read; {o_Pc,o_Instr} = {0,32'hA5A5_0000} then {4,32'hA5A5_0004}; one per cycle.
REQ-041 i_Ready=0, DEPTH=4 -> exactly 4 reads accepted, then o_AV_Read=0; i_Ready pulsed for one cycle -> exactly one new read issued.
REQ-042 Read at 0x10 stalled 3 cycles by WaitRequest -> address stable for 4 cycles; the entry is written once and is correct.
REQ-043 Redirect to 0x100 in the cycle a read of 0x0C returns -> 0x0C is never output; next read at 0x100; the next o_Pc is 0x100.
REQ-044 i_Reset pulsed while a read is in flight and the buffer holds 3 entries -> o_Valid=0 the next cycle; the stale response is dropped; fetch restarts at RESET_PC.
REQ-045 With INSTR_PREFETCH_ALIGN_CHECK_EN defined: redirect to 0x102 -> o_AlignErr=1 and no reads; then redirect to 0x200 -> o_AlignErr=0 and a read at 0x200 the next cycle.
